// File: rtl/fifo_sc_pkg.sv
// Shared types and level helpers for the single-clock usedw FIFO.
// Range checks are constant functions that the top evaluates at elaboration.
package fifo_sc_pkg;

    localparam int AWIDTH_DEF = 4;

    function automatic int usedw_bits(input int awidth);
        return awidth + 1;
    endfunction

    typedef logic [usedw_bits(AWIDTH_DEF)-1:0] usedw_t;

    function automatic bit level_ge(input int cnt, input int lvl);
        return cnt >= lvl;
    endfunction

    function automatic bit level_le(input int cnt, input int lvl);
        return cnt <= lvl;
    endfunction

    function automatic bit af_level_ok(input int lvl, input int depth);
        return (lvl >= 1) && (lvl <= depth);
    endfunction

    function automatic bit ae_level_ok(input int lvl, input int depth);
        return (lvl >= 0) && (lvl <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_sc_usedw_if.sv
// FIFO access bundle: write/read requests, data and occupancy flags.
// ovf_o/udf_o exist only when FIFO_SC_USEDW_ERR_FLAGS_EN is defined.
interface fifo_sc_usedw_if #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
);
    logic              wr_i;
    logic [DWIDTH-1:0] wrdata_i;
    logic              rd_i;
    logic [DWIDTH-1:0] rddata_o;
    logic              empty_o;
    logic              full_o;
    logic              almost_full_o;
    logic              almost_empty_o;
    logic [AWIDTH:0]   usedw_o;
`ifdef FIFO_SC_USEDW_ERR_FLAGS_EN
    logic              ovf_o;
    logic              udf_o;
`endif

    modport master (
        output wr_i, wrdata_i, rd_i,
        input  rddata_o, empty_o, full_o, almost_full_o, almost_empty_o, usedw_o
`ifdef FIFO_SC_USEDW_ERR_FLAGS_EN
        , input ovf_o, udf_o
`endif
    );

    modport slave (
        input  wr_i, wrdata_i, rd_i,
        output rddata_o, empty_o, full_o, almost_full_o, almost_empty_o, usedw_o
`ifdef FIFO_SC_USEDW_ERR_FLAGS_EN
        , output ovf_o, udf_o
`endif
    );

endinterface

// File: rtl/fifo_sc_ram.sv
// Simple dual-port RAM, one write port; the read port is registered (SHOWAHEAD=0) or combinational (SHOWAHEAD=1).
// Registered read updates only on re and holds otherwise; the storage array is never reset.
module fifo_sc_ram #(
    parameter int DWIDTH    = 8,
    parameter int AWIDTH    = 4,
    parameter int SHOWAHEAD = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              re,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem [2**AWIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    generate
        if (SHOWAHEAD != 0) begin : g_async
            logic unused_ctl;
            assign unused_ctl = re | rst_n;
            assign rdata = mem[raddr];
        end else begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata <= '0;
                end else if (re) begin
                    rdata <= mem[raddr];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/fifo_sc_usedw.sv
// Single-clock FIFO with fill level, almost flags and normal/show-ahead read; flags registered from next usedw.
// Writes on full and reads on empty are dropped; FIFO_SC_USEDW_ERR_FLAGS_EN adds sticky ovf_o/udf_o.
module fifo_sc_usedw
    import fifo_sc_pkg::*;
#(
    parameter int DWIDTH    = 8,
    parameter int AWIDTH    = 4,
    parameter int AF_LEVEL  = 12,
    parameter int AE_LEVEL  = 2,
    parameter int SHOWAHEAD = 0
) (
    input  logic           clk_i,
    input  logic           arst_n_i,
    fifo_sc_usedw_if.slave bus
);

    localparam int  DEPTH = 2 ** AWIDTH;
    localparam int  UW    = usedw_bits(AWIDTH);
    localparam bit  AF_OK = af_level_ok(AF_LEVEL, DEPTH);
    localparam bit  AE_OK = ae_level_ok(AE_LEVEL, DEPTH);

    generate
        if (!AF_OK) begin : g_af_range
            $error("fifo_sc_usedw: AF_LEVEL must lie in 1..DEPTH");
        end
        if (!AE_OK) begin : g_ae_range
            $error("fifo_sc_usedw: AE_LEVEL must lie in 0..DEPTH-1");
        end
    endgenerate

    logic [AWIDTH-1:0] wrptr, rdptr;
    logic [UW-1:0]     usedw, usedw_nx;
    logic              empty, full, afull, aempty;
    logic              wr_acc, rd_acc;

    assign wr_acc   = bus.wr_i & ~full;
    assign rd_acc   = bus.rd_i & ~empty;
    assign usedw_nx = usedw + UW'(wr_acc) - UW'(rd_acc);

    // Occupancy alone tells full from empty; pointers may be equal in both cases.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wrptr  <= '0;
            rdptr  <= '0;
            usedw  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            afull  <= 1'b0;
            aempty <= 1'b1;
        end else begin
            if (wr_acc) wrptr <= wrptr + AWIDTH'(1);
            if (rd_acc) rdptr <= rdptr + AWIDTH'(1);
            usedw  <= usedw_nx;
            empty  <= (usedw_nx == '0);
            full   <= (usedw_nx == UW'(DEPTH));
            afull  <= level_ge(int'(usedw_nx), AF_LEVEL);
            aempty <= level_le(int'(usedw_nx), AE_LEVEL);
        end
    end

    fifo_sc_ram #(
        .DWIDTH   (DWIDTH),
        .AWIDTH   (AWIDTH),
        .SHOWAHEAD(SHOWAHEAD)
    ) u_ram (
        .clk  (clk_i),
        .rst_n(arst_n_i),
        .we   (wr_acc),
        .waddr(wrptr),
        .wdata(bus.wrdata_i),
        .re   (rd_acc),
        .raddr(rdptr),
        .rdata(bus.rddata_o)
    );

    assign bus.usedw_o        = usedw;
    assign bus.empty_o        = empty;
    assign bus.full_o         = full;
    assign bus.almost_full_o  = afull;
    assign bus.almost_empty_o = aempty;

`ifdef FIFO_SC_USEDW_ERR_FLAGS_EN
    logic ovf, udf;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (bus.wr_i & full)  ovf <= 1'b1;
            if (bus.rd_i & empty) udf <= 1'b1;
        end
    end

    assign bus.ovf_o = ovf;
    assign bus.udf_o = udf;
`endif

endmodule

// File: tb/tb_fifo_sc_usedw.sv
// Drives a normal-mode and a show-ahead FIFO with identical requests and checks both against a queue model.
module tb_fifo_sc_usedw;
    import fifo_sc_pkg::*;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       wr, rd;
    logic [7:0] wdat;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    logic [7:0] m_rd;
    logic       m_ovf, m_udf;

    always #5 clk = ~clk;

    fifo_sc_usedw_if #(.DWIDTH(8), .AWIDTH(4)) a_if ();
    fifo_sc_usedw_if #(.DWIDTH(8), .AWIDTH(4)) b_if ();

    assign a_if.wr_i     = wr;
    assign a_if.rd_i     = rd;
    assign a_if.wrdata_i = wdat;
    assign b_if.wr_i     = wr;
    assign b_if.rd_i     = rd;
    assign b_if.wrdata_i = wdat;

    fifo_sc_usedw #(.DWIDTH(8), .AWIDTH(4), .AF_LEVEL(12), .AE_LEVEL(2), .SHOWAHEAD(0)) u_dut_a (
        .clk_i   (clk),
        .arst_n_i(arst_n),
        .bus     (a_if)
    );

    fifo_sc_usedw #(.DWIDTH(8), .AWIDTH(4), .AF_LEVEL(12), .AE_LEVEL(2), .SHOWAHEAD(1)) u_dut_b (
        .clk_i   (clk),
        .arst_n_i(arst_n),
        .bus     (b_if)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_rd  = 8'h00;
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    // One clock of requests; the model applies the acceptance rules to the pre-edge occupancy.
    task automatic cycle(input logic w, input logic r, input logic [7:0] d);
        int n;
        wr   = w;
        rd   = r;
        wdat = d;
        n    = q.size();
        if (w && n == DEPTH) m_ovf = 1'b1;
        if (r && n == 0)     m_udf = 1'b1;
        if (r && n > 0)      m_rd = q.pop_front();
        if (w && n < DEPTH)  q.push_back(d);
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        check({tag, "_usedw"},   32'(a_if.usedw_o),        32'(n));
        check({tag, "_usedw_b"}, 32'(b_if.usedw_o),        32'(n));
        check({tag, "_empty"},   32'(a_if.empty_o),        32'(n == 0));
        check({tag, "_full"},    32'(a_if.full_o),         32'(n == DEPTH));
        check({tag, "_af"},      32'(a_if.almost_full_o),  32'(n >= 12));
        check({tag, "_ae"},      32'(a_if.almost_empty_o), 32'(n <= 2));
        check({tag, "_rdata"},   32'(a_if.rddata_o),       32'(m_rd));
        if (n > 0) check({tag, "_head_b"}, 32'(b_if.rddata_o), 32'(q[0]));
`ifdef FIFO_SC_USEDW_ERR_FLAGS_EN
        check({tag, "_ovf"}, 32'(a_if.ovf_o), 32'(m_ovf));
        check({tag, "_udf"}, 32'(a_if.udf_o), 32'(m_udf));
`endif
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_usedw"}, 32'(a_if.usedw_o),        32'd0);
        check({tag, "_empty"}, 32'(a_if.empty_o),        32'd1);
        check({tag, "_full"},  32'(a_if.full_o),         32'd0);
        check({tag, "_ae"},    32'(a_if.almost_empty_o), 32'd1);
        check({tag, "_af"},    32'(a_if.almost_full_o),  32'd0);
        check({tag, "_rdata"}, 32'(a_if.rddata_o),       32'd0);
    endtask

    initial begin
        int p;
        logic w, r;
        usedw_t lvl;

        arst_n = 1'b0;
        wr = 1'b0; rd = 1'b0; wdat = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("por");
        arst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 8'($urandom_range(0, 255)));
            check_all("pre_rst");
        end
        // Asynchronous assertion between edges must clear state at once.
        arst_n = 1'b0;
        #1;
        model_reset();
        check_reset_state("mid_rst");
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b0, 8'(i));
            check("fill_usedw", 32'(a_if.usedw_o), 32'(i + 1));
            if (i + 1 == 2)  check("ae_still_high", 32'(a_if.almost_empty_o), 32'd1);
            if (i + 1 == 3)  check("ae_falls",      32'(a_if.almost_empty_o), 32'd0);
            if (i + 1 == 11) check("af_still_low",  32'(a_if.almost_full_o),  32'd0);
            if (i + 1 == 12) check("af_rises",      32'(a_if.almost_full_o),  32'd1);
            check_all("fill");
        end
        check("full_at_16", 32'(a_if.full_o), 32'd1);
        cycle(1'b1, 1'b0, 8'hAA);
        check("ovf_usedw", 32'(a_if.usedw_o), 32'd16);
        check_all("ovf");
`ifdef FIFO_SC_USEDW_ERR_FLAGS_EN
        check("ovf_flag", 32'(a_if.ovf_o), 32'd1);
`endif

        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            check("drain_data", 32'(a_if.rddata_o), 32'(i));
            check_all("drain");
        end
        check("empty_after_drain", 32'(a_if.empty_o), 32'd1);
        cycle(1'b0, 1'b1, 8'h00);
        check("udf_hold", 32'(a_if.rddata_o), 32'h0F);
        check_all("udf");
`ifdef FIFO_SC_USEDW_ERR_FLAGS_EN
        check("udf_flag", 32'(a_if.udf_o), 32'd1);
`endif

        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'(8'h20 + i));
        cycle(1'b1, 1'b1, 8'h55);
        check("full_rw_usedw", 32'(a_if.usedw_o), 32'd15);
        check("full_rw_data",  32'(a_if.rddata_o), 32'h20);
        check("full_rw_full",  32'(a_if.full_o),   32'd0);
        check_all("full_rw");
        while (q.size() > 0) begin
            cycle(1'b0, 1'b1, 8'h00);
            check_all("drain2");
        end

        cycle(1'b1, 1'b1, 8'h66);
        check("empty_rw_usedw", 32'(a_if.usedw_o), 32'd1);
        check("empty_rw_head",  32'(b_if.rddata_o), 32'h66);
        check_all("empty_rw");
        cycle(1'b0, 1'b1, 8'h00);
        check("empty_rw_read", 32'(a_if.rddata_o), 32'h66);
        check_all("empty_rw_rd");

        cycle(1'b1, 1'b0, 8'h11);
        check("sa_empty_fall", 32'(b_if.empty_o),  32'd0);
        check("sa_head",       32'(b_if.rddata_o), 32'h11);
        cycle(1'b0, 1'b1, 8'h00);
        check("sa_pop_empty",  32'(b_if.empty_o),  32'd1);
        check_all("sa");

        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'(8'h80 + i));
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1, 8'(8'hC0 + i));
            lvl = a_if.usedw_o;
            check("steady_usedw", 32'(lvl), 32'd8);
            check_all("steady");
        end

        // Phases alternate write-heavy, read-heavy and balanced traffic to visit both ends.
        for (int i = 0; i < 10000; i++) begin
            p = (i / 400) % 3;
            case (p)
                0:       begin w = ($urandom_range(0, 99) < 75); r = ($urandom_range(0, 99) < 25); end
                1:       begin w = ($urandom_range(0, 99) < 25); r = ($urandom_range(0, 99) < 75); end
                default: begin w = ($urandom_range(0, 99) < 50); r = ($urandom_range(0, 99) < 50); end
            endcase
            cycle(w, r, 8'($urandom_range(0, 255)));
            check_all("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
